// File: rtl/rx_reader_pkg.sv
// rtl/rx_reader_pkg.sv - shared types and constants for the RX sample reader
//
// Purpose: FSM state encoding, tick-word count and FIFO entry layout shared by
//          rx_samp_reader and rx_reader_fifo.
// Ports:   none (package).
// Config:  RX_READER_TICKS_EN adds the ST_TICKS state to the encoding.
package rx_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CTR   = 3'd1,
    ST_BURST = 3'd2,
    ST_FLUSH = 3'd3
`ifdef RX_READER_TICKS_EN
    , ST_TICKS = 3'd4
`endif
  } rd_state_e;

  // Timestamp words appended to a frame when ticks are enabled (ticks[47:0]).
  localparam int TICK_WORDS = 3;

  // One FIFO entry: end-of-frame tag above the 16-bit memory word.
  typedef struct packed {
    logic        last;
    logic [15:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/rx_samp_reader_if.sv
// rtl/rx_samp_reader_if.sv - memory read port and output stream bundle
//
// Purpose: groups the sample-memory handshake and the output valid/ready stream.
// Signals: get_buf_ctr_C, get_rx_samp_C, reset_bufs_C (reader -> memory),
//          rx_rd_C, rx_dout_C (memory -> reader),
//          m_data, m_valid, m_last (reader -> consumer), m_ready (consumer -> reader).
// Modports: master = reader side, slave = memory/consumer side.
interface rx_samp_reader_if;

  logic        get_buf_ctr_C;
  logic        get_rx_samp_C;
  logic        reset_bufs_C;
  logic        rx_rd_C;
  logic [15:0] rx_dout_C;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;

  modport master (
    output get_buf_ctr_C, get_rx_samp_C, reset_bufs_C,
    input  rx_rd_C, rx_dout_C,
    output m_data, m_valid, m_last,
    input  m_ready
  );

  modport slave (
    input  get_buf_ctr_C, get_rx_samp_C, reset_bufs_C,
    output rx_rd_C, rx_dout_C,
    input  m_data, m_valid, m_last,
    output m_ready
  );

endinterface

// File: rtl/rx_reader_fifo.sv
// rtl/rx_reader_fifo.sv - output FIFO with frame rollback
//
// Purpose: DEPTH-entry FIFO of {last,data} entries, one cycle from push to
//          non-empty. mark records the write pointer at frame start; drop
//          discards the current frame's words that have not been popped yet.
// Ports:   clk, rst_n (async active-low); push/wdata; pop; mark; drop;
//          rdata (head entry); empty; full; free_cnt.
// Config:  none.
module rx_reader_fifo
  import rx_reader_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  fifo_entry_t wdata,
  input  logic        pop,
  input  logic        mark,
  input  logic        drop,
  output fifo_entry_t rdata,
  output logic        empty,
  output logic        full,
  output logic [AW:0] free_cnt
);

  fifo_entry_t mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr, rd_ptr, frm_ptr;
  logic [AW:0] count, rd_nxt, frm_cnt;
  logic        do_push, do_pop;

  assign count    = wr_ptr - rd_ptr;
  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign free_cnt = (AW+1)'(DEPTH) - count;

  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);
  assign rd_nxt  = rd_ptr + (AW+1)'(do_pop);
  assign frm_cnt = wr_ptr - frm_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      frm_ptr <= '0;
    end else begin
      rd_ptr <= rd_nxt;
      if (drop) begin
        // If the consumer already reached into the frame, everything left
        // belongs to it; otherwise rewind to where the frame began.
        wr_ptr <= (frm_cnt >= count) ? rd_nxt : frm_ptr;
      end else if (do_push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (mark) begin
        frm_ptr <= wr_ptr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/rx_samp_reader.sv
// rtl/rx_samp_reader.sv - reads audio sample buffers from memory into a stream
//
// Purpose: on rx_srq_C, reads the buffer counter word then nsamps_C*WORDS_PER_SAMP
//          sample words (one read outstanding at a time) into an output FIFO,
//          tagging the frame's final word with m_last. A read not answered
//          within RD_TIMEOUT cycles aborts the frame, sets err_to and pulses
//          reset_bufs_C.
// Ports:   cpu_clk; reset_n (async active-low); enable; rx_srq_C; nsamps_C;
//          busy; err_to (sticky); clr_err; bus (rx_samp_reader_if.master:
//          memory strobes/response and m_data/m_valid/m_ready/m_last stream).
// Config:  RX_READER_TICKS_EN appends three timestamp reads (TICKS state).
module rx_samp_reader
  import rx_reader_pkg::*;
#(
  parameter int WORDS_PER_SAMP = 3,
  parameter int FIFO_DEPTH     = 64,
  parameter int RD_TIMEOUT     = 15
) (
  input  logic             cpu_clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             rx_srq_C,
  input  logic [15:0]      nsamps_C,
  output logic             busy,
  output logic             err_to,
  input  logic             clr_err,
  rx_samp_reader_if.master bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(RD_TIMEOUT - 1);

  rd_state_e   state, state_nxt;
  logic [31:0] rem, rem_nxt;
  logic        outstanding;
  logic [TW-1:0] tmr;
  logic        err_q, rbuf_q;

  logic        ctr_stb, samp_stb;
  logic        rd_ok, rd_timeout;
  logic        fifo_push, push_last, frame_mark;
  logic        fifo_empty, fifo_full;
  logic [AW:0] free_cnt;
  fifo_entry_t wr_entry, head;

  // Responses with nothing outstanding are stray and ignored.
  assign rd_ok = bus.rx_rd_C && outstanding;
  // tmr counts 1.. from the strobe; last accepted response cycle is RD_TIMEOUT-1.
  assign rd_timeout = outstanding && !bus.rx_rd_C && (tmr == TMR_LAST);

  always_comb begin
    state_nxt  = state;
    rem_nxt    = rem;
    ctr_stb    = 1'b0;
    samp_stb   = 1'b0;
    fifo_push  = 1'b0;
    push_last  = 1'b0;
    frame_mark = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable && rx_srq_C && (free_cnt != '0)) begin
          state_nxt  = ST_CTR;
          rem_nxt    = 32'(nsamps_C) * 32'(WORDS_PER_SAMP);
          frame_mark = 1'b1;
        end
      end
      ST_CTR: begin
        // The free slot checked in IDLE is reserved for the counter word.
        ctr_stb = !outstanding;
        if (rd_ok) begin
          fifo_push = 1'b1;
          if (rem == 32'd0) begin
`ifdef RX_READER_TICKS_EN
            state_nxt = ST_TICKS;
            rem_nxt   = 32'(TICK_WORDS);
`else
            push_last = 1'b1;
            state_nxt = ST_FLUSH;
`endif
          end else begin
            state_nxt = ST_BURST;
          end
        end
      end
      ST_BURST: begin
        samp_stb = !outstanding && !fifo_full;
        if (rd_ok) begin
          fifo_push = 1'b1;
          rem_nxt   = rem - 32'd1;
          if (rem == 32'd1) begin
`ifdef RX_READER_TICKS_EN
            state_nxt = ST_TICKS;
            rem_nxt   = 32'(TICK_WORDS);
`else
            push_last = 1'b1;
            state_nxt = ST_FLUSH;
`endif
          end
        end
      end
`ifdef RX_READER_TICKS_EN
      ST_TICKS: begin
        samp_stb = !outstanding && !fifo_full;
        if (rd_ok) begin
          fifo_push = 1'b1;
          rem_nxt   = rem - 32'd1;
          if (rem == 32'd1) begin
            push_last = 1'b1;
            state_nxt = ST_FLUSH;
          end
        end
      end
`endif
      ST_FLUSH: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (rd_timeout) begin
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      rem         <= '0;
      outstanding <= 1'b0;
      tmr         <= '0;
      err_q       <= 1'b0;
      rbuf_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
      if (ctr_stb || samp_stb) begin
        outstanding <= 1'b1;
        tmr         <= TW'(1);
      end else if (rd_ok || rd_timeout) begin
        outstanding <= 1'b0;
        tmr         <= '0;
      end else if (outstanding) begin
        tmr <= tmr + TW'(1);
      end
      rbuf_q <= rd_timeout;
      // A timeout in the same cycle as clr_err wins.
      if (rd_timeout) begin
        err_q <= 1'b1;
      end else if (clr_err) begin
        err_q <= 1'b0;
      end
    end
  end

  assign wr_entry = {push_last, bus.rx_dout_C};

  rx_reader_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (cpu_clk),
    .rst_n    (reset_n),
    .push     (fifo_push),
    .wdata    (wr_entry),
    .pop      (bus.m_ready),
    .mark     (frame_mark),
    .drop     (rd_timeout),
    .rdata    (head),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .free_cnt (free_cnt)
  );

  assign bus.get_buf_ctr_C = ctr_stb;
  assign bus.get_rx_samp_C = samp_stb;
  assign bus.reset_bufs_C  = rbuf_q;
  // Head RAM is not reset, so data and tag are gated by valid.
  assign bus.m_valid = !fifo_empty;
  assign bus.m_data  = fifo_empty ? 16'h0000 : head.data;
  assign bus.m_last  = !fifo_empty && head.last;
  assign busy        = (state != ST_IDLE);
  assign err_to      = err_q;

endmodule

// File: tb/tb_rx_samp_reader.sv
// tb/tb_rx_samp_reader.sv - scoreboard bench for rx_samp_reader
module tb_rx_samp_reader;

  localparam int WPS   = 3;
  localparam int DEPTH = 4;
  localparam int TMO   = 15;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        srq = 1'b0;
  logic        clr_err = 1'b0;
  logic [15:0] nsamps = 16'h0;
  logic        busy, err_to;

  rx_samp_reader_if bus();

  rx_samp_reader #(
    .WORDS_PER_SAMP (WPS),
    .FIFO_DEPTH     (DEPTH),
    .RD_TIMEOUT     (TMO)
  ) dut (
    .cpu_clk  (clk),
    .reset_n  (rst_n),
    .enable   (enable),
    .rx_srq_C (srq),
    .nsamps_C (nsamps),
    .busy     (busy),
    .err_to   (err_to),
    .clr_err  (clr_err),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [16:0] exp_q[$];
  logic [15:0] mem_q[$];
  logic [15:0] ctr_word = 16'h0;
  int stb_idx = 0, ctr_cnt = 0, ignore_idx = -1, ign_cyc = 0, rbuf_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Memory model: answers each strobe LAT cycles later, except the ignored one.
  initial begin : memory
    int resp_t;
    logic [15:0] resp_d, d;
    resp_t = 0;
    resp_d = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      bus.rx_rd_C = 1'b0;
      if (!rst_n) begin
        resp_t = 0;
      end else begin
        if (resp_t > 0) begin
          resp_t--;
          if (resp_t == 0) begin
            bus.rx_rd_C   = 1'b1;
            bus.rx_dout_C = resp_d;
          end
        end
        if (bus.get_buf_ctr_C || bus.get_rx_samp_C) begin
          stb_idx++;
          if (bus.get_buf_ctr_C) begin
            ctr_cnt++;
            d = ctr_word;
          end else begin
            d = (mem_q.size() > 0) ? mem_q.pop_front() : 16'hDEAD;
          end
          if (stb_idx == ignore_idx) begin
            ign_cyc = cyc;
          end else begin
            resp_t = LAT;
            resp_d = d;
          end
        end
      end
    end
  end

  // Output monitor: pops the scoreboard on every accepted stream word.
  initial begin : monitor
    logic [16:0] e;
    forever begin
      @(negedge clk);
      if (bus.reset_bufs_C) rbuf_cnt++;
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_word: got %h last %0d expected none", bus.m_data, bus.m_last);
        end else begin
          e = exp_q.pop_front();
          chk("word_data", {16'h0, bus.m_data}, {16'h0, e[15:0]});
          chk("word_last", {31'h0, bus.m_last}, {31'h0, e[16]});
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Queues the frame: counter word, samples (and ticks LS..MS), last tag on the end.
  task automatic load_frame(input int ns, input logic [15:0] ctr, input logic [15:0] base,
                            input int keep);
    logic [15:0] w[$];
    int k;
    w.push_back(ctr);
    for (int i = 0; i < ns * WPS; i++) begin
      w.push_back(base + 16'(i));
      mem_q.push_back(base + 16'(i));
    end
`ifdef RX_READER_TICKS_EN
    w.push_back(16'h5678); mem_q.push_back(16'h5678);
    w.push_back(16'h1234); mem_q.push_back(16'h1234);
    w.push_back(16'hABCD); mem_q.push_back(16'hABCD);
`endif
    ctr_word = ctr;
    k = (keep < 0) ? w.size() : keep;
    for (int i = 0; i < k; i++) begin
      exp_q.push_back({(i == w.size() - 1), w[i]});
    end
    nsamps = 16'(ns);
  endtask

  task automatic start_frame(input string name);
    int c0 = ctr_cnt;
    int n = 0;
    srq = 1'b1;
    while (ctr_cnt == c0 && n < 50) begin
      step(1);
      n++;
    end
    srq = 1'b0;
    chk({name, "_start"}, {31'h0, n < 50}, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 400) begin
      step(1);
      n++;
    end
    chk({name, "_done"}, {31'h0, n < 400}, 32'd1);
    chk({name, "_busy"}, {31'h0, busy}, 32'd0);
  endtask

  initial begin : stim
    int s0, r0, n, t_err;
    bus.rx_rd_C   = 1'b0;
    bus.rx_dout_C = 16'h0;
    bus.m_ready   = 1'b0;
    #1;
    chk("rst_busy",    {31'h0, busy}, 32'd0);
    chk("rst_err",     {31'h0, err_to}, 32'd0);
    chk("rst_valid",   {31'h0, bus.m_valid}, 32'd0);
    chk("rst_last",    {31'h0, bus.m_last}, 32'd0);
    chk("rst_strobes", {29'h0, bus.get_buf_ctr_C, bus.get_rx_samp_C, bus.reset_bufs_C}, 32'd0);
    step(2);
    rst_n = 1'b1;
    enable = 1'b1;
    bus.m_ready = 1'b1;
    step(2);

    // Two samples: counter + 6 words, m_last on the final one.
    load_frame(2, 16'hC001, 16'h1000, -1);
    start_frame("f2");
    wait_idle("f2");

    // Zero samples: counter word alone carries m_last.
    load_frame(0, 16'hC002, 16'h0000, -1);
    start_frame("f0");
    wait_idle("f0");

    // Stalled consumer: reads stop once the FIFO is full, then drain in order.
    bus.m_ready = 1'b0;
    s0 = stb_idx;
    load_frame(4, 16'hC003, 16'h2000, -1);
    start_frame("stall");
    step(60);
    chk("stall_strobes", stb_idx - s0, DEPTH);
    chk("stall_valid", {31'h0, bus.m_valid}, 32'd1);
    chk("stall_head", {16'h0, bus.m_data}, 32'h0000C003);
    chk("stall_last", {31'h0, bus.m_last}, 32'd0);
    bus.m_ready = 1'b1;
    wait_idle("stall");

    // Enable dropped mid-frame: frame still completes.
    load_frame(1, 16'hC004, 16'h3000, -1);
    start_frame("en");
    enable = 1'b0;
    wait_idle("en");
    enable = 1'b1;

    // Third strobe never answered: timeout, abort, reset_bufs pulse.
    r0 = rbuf_cnt;
    ignore_idx = stb_idx + 3;
    load_frame(2, 16'hC005, 16'h4000, 2);
    start_frame("to");
    n = 0;
    while (!err_to && n < 100) begin
      step(1);
      n++;
    end
    t_err = cyc;
    chk("to_seen", {31'h0, err_to}, 32'd1);
    chk("to_cycle", t_err - ign_cyc, TMO);
    chk("to_busy", {31'h0, busy}, 32'd0);
    step(5);
    chk("to_rbuf_pulses", rbuf_cnt - r0, 32'd1);
    chk("to_dropped", exp_q.size(), 32'd0);
    chk("to_valid", {31'h0, bus.m_valid}, 32'd0);
    chk("to_sticky", {31'h0, err_to}, 32'd1);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    chk("to_clr", {31'h0, err_to}, 32'd0);
    ignore_idx = -1;
    mem_q.delete();

    // Reset in the middle of a burst.
    r0 = rbuf_cnt;
    s0 = stb_idx;
    load_frame(4, 16'hC006, 16'h5000, -1);
    start_frame("rst");
    n = 0;
    while (stb_idx < s0 + 3 && n < 50) begin
      step(1);
      n++;
    end
    chk("rst_mid_reached", {31'h0, n < 50}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstm_busy", {31'h0, busy}, 32'd0);
    chk("rstm_valid", {31'h0, bus.m_valid}, 32'd0);
    chk("rstm_last", {31'h0, bus.m_last}, 32'd0);
    chk("rstm_data", {16'h0, bus.m_data}, 32'd0);
    chk("rstm_strobes", {29'h0, bus.get_buf_ctr_C, bus.get_rx_samp_C, bus.reset_bufs_C}, 32'd0);
    exp_q.delete();
    mem_q.delete();
    step(3);
    chk("rstm_no_rbuf", rbuf_cnt - r0, 32'd0);
    rst_n = 1'b1;
    step(2);

    // Clean frame after reset.
    load_frame(1, 16'hC007, 16'h6000, -1);
    start_frame("post");
    wait_idle("post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
